// File: rtl/result_consumer_pkg.sv
// Shared encodings and widths for the result consumer and its statistics datapath.
package result_consumer_pkg;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 8;
  localparam int SUM_W   = 24;

  localparam logic [DATA_W-1:0]  MIN_RESET = 16'hFFFF;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DELAY     = 2'd1,
    S_WAIT_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/result_consumer_stats.sv
// Running statistics over captured data: saturating count, sum, unsigned min/max, sticky sat.
// Results are registered and visible the cycle after capture; a clear on a capture edge restarts from that datum.
module result_stats
  import result_consumer_pkg::*;
(
  input  logic               clock,
  input  logic               reset_,
  input  logic [DATA_W-1:0]  datum,
  input  logic               capture,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic [SUM_W-1:0]   sum,
  output logic [DATA_W-1:0]  minimum,
  output logic [DATA_W-1:0]  maximum,
  output logic               sat
);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      count   <= '0;
      sum     <= '0;
      minimum <= MIN_RESET;
      maximum <= '0;
      sat     <= 1'b0;
    end else if (capture && clear) begin
      count   <= COUNT_W'(1);
      sum     <= SUM_W'(datum);
      minimum <= datum;
      maximum <= datum;
      sat     <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      sum     <= '0;
      minimum <= MIN_RESET;
      maximum <= '0;
      sat     <= 1'b0;
    end else if (capture) begin
      // Count and sum freeze once saturated; 255 * 16'hFFFF still fits in 24 bits.
      if (count != COUNT_MAX) begin
        count <= count + COUNT_W'(1);
        sum   <= sum + SUM_W'(datum);
      end
      if (count == COUNT_MAX - COUNT_W'(1)) sat <= 1'b1;
      if (datum < minimum) minimum <= datum;
      if (datum > maximum) maximum <= datum;
    end
  end

endmodule

// File: rtl/result_consumer.sv
// Consumes data from an active-low dav_ producer, holding rfd high for 'delay' extra edges after capture.
// rfd then drops until dav_ returns high; statistics are kept by result_stats.
module result_consumer
  import result_consumer_pkg::*;
#(
  parameter int DELAY_W = 4
) (
  input  logic               clock,
  input  logic               reset_,
  input  logic               dav_,
  input  logic [DATA_W-1:0]  result,
  output logic               rfd,
  input  logic [DELAY_W-1:0] delay,
  input  logic               clear,
  output logic [DATA_W-1:0]  last,
  output logic [COUNT_W-1:0] count,
  output logic [SUM_W-1:0]   sum,
  output logic [DATA_W-1:0]  minimum,
  output logic [DATA_W-1:0]  maximum,
  output logic               sat
);

  state_t             state;
  logic [DELAY_W-1:0] dly_cnt;
  logic               capture;

  // Only the first low sample in S_IDLE captures; later result changes are ignored.
  assign capture = (state == S_IDLE) && !dav_;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= S_IDLE;
      rfd     <= 1'b1;
      dly_cnt <= '0;
      last    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rfd <= 1'b1;
          if (!dav_) begin
            last    <= result;
            dly_cnt <= delay;
            state   <= S_DELAY;
          end
        end
        S_DELAY: begin
          // dav_ is not looked at here, so an early release still yields an rfd low pulse.
          if (dly_cnt == '0) begin
            rfd   <= 1'b0;
            state <= S_WAIT_HIGH;
          end else begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (dav_) begin
            rfd   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          rfd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  result_stats u_stats (
    .clock   (clock),
    .reset_  (reset_),
    .datum   (result),
    .capture (capture),
    .clear   (clear),
    .count   (count),
    .sum     (sum),
    .minimum (minimum),
    .maximum (maximum),
    .sat     (sat)
  );

endmodule

// File: tb/tb_result_consumer.sv
// Directed bench: a producer task queues the expected statistics per handshake; a monitor checks them on each rfd fall.
module tb_result_consumer;

  localparam int DELAY_W = 4;

  logic               clock = 1'b0;
  logic               reset_;
  logic               dav_;
  logic [15:0]        result;
  logic               rfd;
  logic [DELAY_W-1:0] delay;
  logic               clear;
  logic [15:0]        last;
  logic [7:0]         count;
  logic [23:0]        sum;
  logic [15:0]        minimum;
  logic [15:0]        maximum;
  logic               sat;

  typedef struct {
    logic [15:0] last;
    logic [7:0]  count;
    logic [23:0] sum;
    logic [15:0] mn;
    logic [15:0] mx;
    logic        sat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  logic prev_rfd = 1'b1;

  always #5 clock = ~clock;

  result_consumer #(.DELAY_W(DELAY_W)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .dav_    (dav_),
    .result  (result),
    .rfd     (rfd),
    .delay   (delay),
    .clear   (clear),
    .last    (last),
    .count   (count),
    .sum     (sum),
    .minimum (minimum),
    .maximum (maximum),
    .sat     (sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic exp_t mk(input logic [15:0] l, input logic [7:0] c, input logic [23:0] s,
                              input logic [15:0] mn, input logic [15:0] mx, input logic st);
    exp_t e;
    e.last = l; e.count = c; e.sum = s; e.mn = mn; e.mx = mx; e.sat = st;
    return e;
  endfunction

  task automatic wait_rfd(input logic v);
    int n = 0;
    while (rfd !== v && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("wait_rfd", 32'(rfd), 32'(v));
  endtask

  // One handshake; checks rfd holds high for exactly dl edges after the capture edge.
  task automatic send(input logic [15:0] d, input int dl, input bit clr, input bit early, input exp_t e);
    int hi = 0;
    int n  = 0;
    wait_rfd(1'b1);
    @(negedge clock);
    q.push_back(e);
    result = d;
    delay  = DELAY_W'(dl);
    clear  = clr;
    dav_   = 1'b0;
    @(posedge clock);
    #1;
    clear  = 1'b0;
    result = ~d;
    if (early) dav_ = 1'b1;
    do begin
      @(posedge clock);
      #1;
      if (rfd) hi++;
      n++;
    end while (rfd && n < 40);
    chk("rfd_hold_edges", 32'(hi), 32'(dl));
    if (early) begin
      @(posedge clock);
      #1;
      chk("rfd_rise_early", 32'(rfd), 32'd1);
    end else begin
      repeat (2) begin
        @(posedge clock);
        #1;
        chk("rfd_wait_low", 32'(rfd), 32'd0);
      end
      @(negedge clock);
      dav_ = 1'b1;
      @(posedge clock);
      #1;
      chk("rfd_rise", 32'(rfd), 32'd1);
    end
  endtask

  always @(negedge clock) begin
    if (reset_ && prev_rfd && !rfd) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_handshake: got rfd fall, required none pending");
      end else begin
        mon_e = q.pop_front();
        chk("last",    32'(last),    32'(mon_e.last));
        chk("count",   32'(count),   32'(mon_e.count));
        chk("sum",     32'(sum),     32'(mon_e.sum));
        chk("minimum", 32'(minimum), 32'(mon_e.mn));
        chk("maximum", 32'(maximum), 32'(mon_e.mx));
        chk("sat",     32'(sat),     32'(mon_e.sat));
      end
    end
    prev_rfd = rfd;
  end

  initial begin
    reset_ = 1'b0;
    dav_   = 1'b1;
    result = '0;
    delay  = '0;
    clear  = 1'b0;
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    chk("rst_rfd",     32'(rfd),     32'd1);
    chk("rst_last",    32'(last),    32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_sum",     32'(sum),     32'd0);
    chk("rst_minimum", 32'(minimum), 32'hFFFF);
    chk("rst_maximum", 32'(maximum), 32'd0);
    chk("rst_sat",     32'(sat),     32'd0);

    send(16'd380, 0, 1'b0, 1'b0, mk(16'd380, 8'd1, 24'd380,  16'd380, 16'd380, 1'b0));
    send(16'd425, 0, 1'b0, 1'b1, mk(16'd425, 8'd2, 24'd805,  16'd380, 16'd425, 1'b0));
    send(16'd470, 0, 1'b0, 1'b0, mk(16'd470, 8'd3, 24'd1275, 16'd380, 16'd470, 1'b0));
    send(16'd255, 5, 1'b0, 1'b0, mk(16'd255, 8'd4, 24'd1530, 16'd255, 16'd470, 1'b0));
    send(16'd1000, 2, 1'b1, 1'b0, mk(16'd1000, 8'd1, 24'd1000, 16'd1000, 16'd1000, 1'b0));

    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_count",   32'(count),   32'd0);
    chk("clr_sum",     32'(sum),     32'd0);
    chk("clr_minimum", 32'(minimum), 32'hFFFF);
    chk("clr_maximum", 32'(maximum), 32'd0);
    chk("clr_last",    32'(last),    32'd1000);

    for (int i = 1; i <= 256; i++) begin
      logic [7:0] c;
      c = (i < 255) ? 8'(i) : 8'd255;
      send(16'hFFFF, 0, 1'b0, 1'b0,
           mk(16'hFFFF, c, 24'(32'(c) * 65535), 16'hFFFF, 16'hFFFF, (i >= 255)));
    end
    send(16'd7, 1, 1'b0, 1'b0, mk(16'd7, 8'd255, 24'd16711425, 16'd7, 16'hFFFF, 1'b1));

    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    q.push_back(mk(16'd42, 8'd1, 24'd42, 16'd42, 16'd42, 1'b0));
    q.push_back(mk(16'd42, 8'd1, 24'd42, 16'd42, 16'd42, 1'b0));
    delay  = '0;
    result = 16'd42;
    dav_   = 1'b0;
    wait_rfd(1'b0);
    @(negedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    chk("midrst_rfd",     32'(rfd),     32'd1);
    chk("midrst_count",   32'(count),   32'd0);
    chk("midrst_last",    32'(last),    32'd0);
    chk("midrst_minimum", 32'(minimum), 32'hFFFF);
    @(negedge clock);
    reset_ = 1'b1;
    wait_rfd(1'b0);
    @(negedge clock);
    dav_ = 1'b1;
    wait_rfd(1'b1);

    repeat (4) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
